// File: rtl/turn_control.sv
// Per-player turn controller: mouse clicks queue a turn, and each movement tick applies one queued turn.
// Optional TURN_QUEUE_EN: 2-entry turn FIFO per player (default: 1 entry, newest click wins).
module turn_control #(
    parameter int NUM_PLAYERS = 2,
    parameter int TICK_CYCLES = 8_125_000
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    mouse_right,
    input  logic                                                    mouse_left,
    input  logic                                                    sel_valid,
    input  logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] player_sel,
    output logic [3*NUM_PLAYERS-1:0]                                direction,
    output logic                                                    tick,
    output logic [NUM_PLAYERS-1:0]                                  dir_changed
);

    localparam int            CW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
`ifdef TURN_QUEUE_EN
    localparam int QD = 2;
`else
    localparam int QD = 1;
`endif

    localparam logic [2:0] D_WAIT  = 3'd0;
    localparam logic [2:0] D_RIGHT = 3'd1;
    localparam logic [2:0] D_DOWN  = 3'd2;
    localparam logic [2:0] D_LEFT  = 3'd3;
    localparam logic [2:0] D_UP    = 3'd4;

    logic [CW-1:0]            r_count;
    logic                     r_mr;
    logic                     r_ml;
    logic [3*NUM_PLAYERS-1:0] r_dir;
    logic [2*NUM_PLAYERS-1:0] r_qcnt;
    logic [NUM_PLAYERS-1:0]   r_qhead;
    logic [NUM_PLAYERS-1:0]   r_qtail;
    logic                     r_tick;
    logic [NUM_PLAYERS-1:0]   r_chg;

    logic                     w_tick_cond;
    logic                     w_click_r;
    logic                     w_click_l;
    logic                     w_sel_ok;
    logic                     w_click_valid;
    logic [3*NUM_PLAYERS-1:0] w_dir_nxt;
    logic [2*NUM_PLAYERS-1:0] w_qcnt_nxt;
    logic [NUM_PLAYERS-1:0]   w_qhead_nxt;
    logic [NUM_PLAYERS-1:0]   w_qtail_nxt;
    logic [NUM_PLAYERS-1:0]   w_chg;

    // Queue entries store the turn sense only: 1 = clockwise, 0 = counter-clockwise.
    function automatic logic [2:0] f_turn(input logic [2:0] d, input logic right);
        logic [2:0] n;
        case (d)
            D_WAIT:  n = right ? D_RIGHT : D_LEFT;
            D_RIGHT: n = right ? D_DOWN  : D_UP;
            D_DOWN:  n = right ? D_LEFT  : D_RIGHT;
            D_LEFT:  n = right ? D_UP    : D_DOWN;
            D_UP:    n = right ? D_RIGHT : D_LEFT;
            default: n = D_WAIT;
        endcase
        return n;
    endfunction

    assign w_tick_cond   = (r_count == C_LAST);
    assign w_click_r     = mouse_right & ~r_mr;
    assign w_click_l     = mouse_left & ~r_ml;
    assign w_sel_ok      = (int'(player_sel) < NUM_PLAYERS);
    // Simultaneous right and left clicks cancel each other out.
    assign w_click_valid = (w_click_r ^ w_click_l) & sel_valid & w_sel_ok;

    always_comb begin : p_next
        logic [2:0] v_cur;
        logic [2:0] v_new;
        logic [1:0] v_cnt;
        logic       v_head;
        logic       v_tail;
        logic       v_push;
        w_dir_nxt   = r_dir;
        w_qcnt_nxt  = r_qcnt;
        w_qhead_nxt = r_qhead;
        w_qtail_nxt = r_qtail;
        w_chg       = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            v_cur  = r_dir[3*p +: 3];
            v_new  = v_cur;
            v_cnt  = r_qcnt[2*p +: 2];
            v_head = r_qhead[p];
            v_tail = r_qtail[p];
            v_push = w_click_valid && (int'(player_sel) == p);
            if (w_tick_cond) begin
                if (!sel_valid) begin
                    v_new = D_WAIT;
                    v_cnt = 2'd0;
                end else if (v_cnt != 2'd0) begin
                    v_new  = f_turn(v_cur, v_head);
                    v_head = v_tail;
                    v_cnt  = v_cnt - 2'd1;
                end else if (v_cur > D_UP) begin
                    v_new = D_WAIT;
                end
                w_chg[p] = (v_new != v_cur);
            end
            // Push after the pop so a click in the tick cycle lands on the next tick.
            if (v_push) begin
                if (v_cnt == 2'd0) begin
                    v_head = w_click_r;
                    v_cnt  = 2'd1;
                end else if (QD == 1) begin
                    v_head = w_click_r;
                end else if (v_cnt == 2'd1) begin
                    v_tail = w_click_r;
                    v_cnt  = 2'd2;
                end
            end
            w_dir_nxt[3*p +: 3]  = v_new;
            w_qcnt_nxt[2*p +: 2] = v_cnt;
            w_qhead_nxt[p]       = v_head;
            w_qtail_nxt[p]       = v_tail;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_mr    <= 1'b0;
            r_ml    <= 1'b0;
            r_dir   <= '0;
            r_qcnt  <= '0;
            r_qhead <= '0;
            r_qtail <= '0;
            r_tick  <= 1'b0;
            r_chg   <= '0;
        end else begin
            r_count <= w_tick_cond ? '0 : r_count + C_ONE;
            r_mr    <= mouse_right;
            r_ml    <= mouse_left;
            r_dir   <= w_dir_nxt;
            r_qcnt  <= w_qcnt_nxt;
            r_qhead <= w_qhead_nxt;
            r_qtail <= w_qtail_nxt;
            r_tick  <= w_tick_cond;
            r_chg   <= w_chg;
        end
    end

    assign direction   = r_dir;
    assign tick        = r_tick;
    assign dir_changed = r_chg;

endmodule
